// File: rtl/processor_stage1_pkg.sv
// Shared definitions for the processor front end: size defaults, opcode
// constants, and the next-address source encoding used by the fetch stage.
package processor_stage1_pkg;

  localparam int DEF_ADDR_SIZE  = 18;
  localparam int DEF_WORD_SIZE  = 18;
  localparam int DEF_RESET_ADDR = 0;
  localparam int DEF_CNT_SIZE   = 32;

  // Opcode field values decoded by stage2; stage1 never looks inside a word.
  localparam logic [4:0] OP_NOP    = 5'h00;
  localparam logic [4:0] OP_CALL   = 5'h01;
  localparam logic [4:0] OP_IF     = 5'h02;
  localparam logic [4:0] OP_RETURN = 5'h03;
  localparam logic [4:0] OP_WAIT   = 5'h04;
  localparam logic [4:0] OP_LOAD   = 5'h05;
  localparam logic [4:0] OP_STORE  = 5'h06;

  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_HOLD,
    SEL_RETURN,
    SEL_CALL,
    SEL_REFETCH,
    SEL_SEQUENTIAL
  } next_sel_t;

endpackage

// File: rtl/processor_stage1_if.sv
// Fetch-stage bus: code memory port, stage2 redirect controls and the
// fetched-word bundle handed to stage2.
interface processor_stage1_if
  import processor_stage1_pkg::*;
#(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int CNT_SIZE  = DEF_CNT_SIZE
);

  logic [ADDR_SIZE-1:0] code_addr;
  logic [WORD_SIZE-1:0] code_rdata;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 call_performed;
  logic [ADDR_SIZE-1:0] ip_to_call;
  logic                 return_performed;
  logic                 waiting_global;
  logic                 debug_halt;
  logic                 no_operation;
  logic [ADDR_SIZE-1:0] ip;
  logic [ADDR_SIZE-1:0] ip_plus_one;
  logic [WORD_SIZE-1:0] code_word;
  logic [CNT_SIZE-1:0]  fetch_count;

  modport master (
    output code_addr, no_operation, ip, ip_plus_one, code_word, fetch_count,
    input  code_rdata, mem_rdata, call_performed, ip_to_call,
           return_performed, waiting_global, debug_halt
  );

  modport slave (
    input  code_addr, no_operation, ip, ip_plus_one, code_word, fetch_count,
    output code_rdata, mem_rdata, call_performed, ip_to_call,
           return_performed, waiting_global, debug_halt
  );

endinterface

// File: rtl/processor_next_ip.sv
// Combinational priority mux choosing the next code memory address.
module processor_next_ip
  import processor_stage1_pkg::*;
#(
  parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int RESET_ADDR = DEF_RESET_ADDR
) (
  input  logic                 reset,
  input  logic                 hold,
  input  logic                 return_performed,
  input  logic [ADDR_SIZE-1:0] return_addr,
  input  logic                 call_performed,
  input  logic [ADDR_SIZE-1:0] call_addr,
  input  logic                 valid_q,
  input  logic [ADDR_SIZE-1:0] pc_q,
  output logic [ADDR_SIZE-1:0] next_addr
);

  localparam logic [ADDR_SIZE-1:0] RESET_IP = ADDR_SIZE'(RESET_ADDR);

  next_sel_t sel;

  // A return outranks a call so a conflicting pair can never skip the return.
  always_comb begin
    sel = SEL_SEQUENTIAL;
    if (reset)                 sel = SEL_RESET;
    else if (hold)             sel = SEL_HOLD;
    else if (return_performed) sel = SEL_RETURN;
    else if (call_performed)   sel = SEL_CALL;
    else if (!valid_q)         sel = SEL_REFETCH;
  end

  always_comb begin
    next_addr = pc_q + ADDR_SIZE'(1);
    case (sel)
      SEL_RESET:   next_addr = RESET_IP;
      SEL_HOLD:    next_addr = pc_q;
      SEL_RETURN:  next_addr = return_addr;
      SEL_CALL:    next_addr = call_addr;
      SEL_REFETCH: next_addr = pc_q;
      default:     next_addr = pc_q + ADDR_SIZE'(1);
    endcase
  end

endmodule

// File: rtl/processor_stage1.sv
// Instruction fetch stage: owns the instruction pointer, drives the synchronous
// code memory and presents each returned word to stage2 unregistered.
module processor_stage1
  import processor_stage1_pkg::*;
#(
  parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int RESET_ADDR = DEF_RESET_ADDR,
  parameter int CNT_SIZE   = DEF_CNT_SIZE
) (
  input  logic                 clock,
  input  logic                 reset,
  processor_stage1_if.master   bus
);

  logic [ADDR_SIZE-1:0] pc_q;
  logic [ADDR_SIZE-1:0] next_addr;
  logic                 valid_q;
  logic [CNT_SIZE-1:0]  fetch_count_q;
  logic                 no_op;

  processor_next_ip #(
    .ADDR_SIZE  (ADDR_SIZE),
    .RESET_ADDR (RESET_ADDR)
  ) u_next_ip (
    .reset            (reset),
    .hold             (bus.waiting_global | bus.debug_halt),
    .return_performed (bus.return_performed),
    .return_addr      (bus.mem_rdata[ADDR_SIZE-1:0]),
    .call_performed   (bus.call_performed),
    .call_addr        (bus.ip_to_call),
    .valid_q          (valid_q),
    .pc_q             (pc_q),
    .next_addr        (next_addr)
  );

  assign no_op = !valid_q | bus.return_performed | bus.waiting_global | bus.debug_halt;

  // pc_q always tracks the address whose data is on code_rdata, so a halt
  // that re-reads pc_q keeps the presented word consistent with ip.
  always_ff @(posedge clock) begin
    pc_q    <= next_addr;
    valid_q <= !reset;
  end

  always_ff @(posedge clock) begin
    if (reset)
      fetch_count_q <= '0;
    else if (!no_op && fetch_count_q != '1)
      fetch_count_q <= fetch_count_q + CNT_SIZE'(1);
  end

  assign bus.code_addr    = next_addr;
  assign bus.no_operation = no_op;
  assign bus.ip           = pc_q;
  assign bus.ip_plus_one  = pc_q + ADDR_SIZE'(1);
  assign bus.code_word    = bus.code_rdata;
  assign bus.fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_processor_stage1.sv
// Directed bench for the fetch stage: a vector table for fetch/call/return,
// plus hand sequences for wait, wrap, debug halt and counter saturation.
module tb_processor_stage1;
  import processor_stage1_pkg::*;

  typedef struct packed {
    logic        call;
    logic [17:0] tgt;
    logic        ret;
    logic [17:0] mrd;
    logic        no_op;
    logic [17:0] ip;
    logic [17:0] addr;
    logic [31:0] fc;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs [14];

  processor_stage1_if #(.ADDR_SIZE(18), .WORD_SIZE(18), .CNT_SIZE(32)) bus ();
  processor_stage1_if #(.ADDR_SIZE(18), .WORD_SIZE(18), .CNT_SIZE(4))  sbus ();

  processor_stage1 #(.ADDR_SIZE(18), .WORD_SIZE(18), .RESET_ADDR(0), .CNT_SIZE(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  processor_stage1 #(.ADDR_SIZE(18), .WORD_SIZE(18), .RESET_ADDR(0), .CNT_SIZE(4)) dut_small (
    .clock (clock),
    .reset (reset),
    .bus   (sbus)
  );

  always #5 clock = ~clock;

  // Code memory model: one-cycle read latency, contents a fixed scramble of the address.
  function automatic logic [17:0] mem_word(input logic [17:0] a);
    return a ^ 18'h2A5A5;
  endfunction

  always @(posedge clock) begin
    bus.code_rdata  <= mem_word(bus.code_addr);
    sbus.code_rdata <= mem_word(sbus.code_addr);
  end

  initial begin
    sbus.mem_rdata        = '0;
    sbus.call_performed   = 1'b0;
    sbus.ip_to_call       = '0;
    sbus.return_performed = 1'b0;
    sbus.waiting_global   = 1'b0;
    sbus.debug_halt       = 1'b0;
  end

  function automatic vec_t mk(input logic call, input logic [17:0] tgt, input logic ret,
                              input logic [17:0] mrd, input logic no_op, input logic [17:0] ip,
                              input logic [17:0] addr, input logic [31:0] fc);
    vec_t v;
    v = '{call, tgt, ret, mrd, no_op, ip, addr, fc};
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    bus.mem_rdata        = '0;
    bus.call_performed   = 1'b0;
    bus.ip_to_call       = '0;
    bus.return_performed = 1'b0;
    bus.waiting_global   = 1'b0;
    bus.debug_halt       = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.call_performed   = v.call;
    bus.ip_to_call       = v.tgt;
    bus.return_performed = v.ret;
    bus.mem_rdata        = v.mrd;
    bus.waiting_global   = 1'b0;
    bus.debug_halt       = 1'b0;
  endtask

  task automatic checkMain(input string tag, input logic exp_no_op, input logic [17:0] exp_ip);
    logic [17:0] nxt;
    nxt = exp_ip + 18'd1;
    checkOutput({tag, ".no_op"}, 32'(bus.no_operation), 32'(exp_no_op));
    checkOutput({tag, ".ip"}, 32'(bus.ip), 32'(exp_ip));
    checkOutput({tag, ".ip_plus_one"}, 32'(bus.ip_plus_one), 32'(nxt));
    checkOutput({tag, ".code_word"}, 32'(bus.code_word), 32'(mem_word(exp_ip)));
  endtask

  // Leaves the bench inside the first post-reset cycle, reset already released.
  task automatic applyReset(input int n);
    @(negedge clock);
    reset = 1'b1;
    repeat (n) @(negedge clock);
    #1;
    checkOutput("rst.no_op", 32'(bus.no_operation), 32'd1);
    checkOutput("rst.ip", 32'(bus.ip), 32'd0);
    checkOutput("rst.code_addr", 32'(bus.code_addr), 32'd0);
    checkOutput("rst.fetch_count", bus.fetch_count, 32'd0);
    reset = 1'b0;
    clearInputs();
  endtask

  initial begin
    vecs[0]  = mk(1'b0, 18'h0,     1'b0, 18'h0,   1'b1, 18'h0,     18'h0,     32'd0);
    vecs[1]  = mk(1'b0, 18'h0,     1'b0, 18'h0,   1'b0, 18'h0,     18'h1,     32'd0);
    vecs[2]  = mk(1'b0, 18'h0,     1'b0, 18'h0,   1'b0, 18'h1,     18'h2,     32'd1);
    vecs[3]  = mk(1'b0, 18'h0,     1'b0, 18'h0,   1'b0, 18'h2,     18'h3,     32'd2);
    vecs[4]  = mk(1'b0, 18'h0,     1'b0, 18'h0,   1'b0, 18'h3,     18'h4,     32'd3);
    vecs[5]  = mk(1'b0, 18'h0,     1'b0, 18'h0,   1'b0, 18'h4,     18'h5,     32'd4);
    vecs[6]  = mk(1'b1, 18'h40,    1'b0, 18'h0,   1'b0, 18'h5,     18'h40,    32'd5);
    vecs[7]  = mk(1'b0, 18'h0,     1'b0, 18'h0,   1'b0, 18'h40,    18'h41,    32'd6);
    vecs[8]  = mk(1'b1, 18'h8,     1'b0, 18'h0,   1'b0, 18'h41,    18'h8,     32'd7);
    vecs[9]  = mk(1'b0, 18'h0,     1'b1, 18'h123, 1'b1, 18'h8,     18'h123,   32'd8);
    vecs[10] = mk(1'b0, 18'h0,     1'b0, 18'h0,   1'b0, 18'h123,   18'h124,   32'd8);
    vecs[11] = mk(1'b1, 18'h300,   1'b1, 18'h200, 1'b1, 18'h124,   18'h200,   32'd9);
    vecs[12] = mk(1'b0, 18'h0,     1'b0, 18'h0,   1'b0, 18'h200,   18'h201,   32'd9);
    vecs[13] = mk(1'b0, 18'h0,     1'b0, 18'h0,   1'b0, 18'h201,   18'h202,   32'd10);

    clearInputs();
    applyReset(3);

    for (int i = 0; i < 14; i++) begin
      if (i > 0) @(negedge clock);
      applyStimulus(vecs[i]);
      #1;
      checkMain($sformatf("vec%0d", i), vecs[i].no_op, vecs[i].ip);
      checkOutput($sformatf("vec%0d.code_addr", i), 32'(bus.code_addr), 32'(vecs[i].addr));
      checkOutput($sformatf("vec%0d.fetch_count", i), bus.fetch_count, vecs[i].fc);
    end

    // Wait: jump to 0x10 then hold there until a reset.
    @(negedge clock);
    clearInputs();
    bus.call_performed = 1'b1;
    bus.ip_to_call     = 18'h10;
    #1;
    checkMain("wait_pre", 1'b0, 18'h202);
    checkOutput("wait_pre.fetch_count", bus.fetch_count, 32'd11);
    @(negedge clock);
    bus.call_performed = 1'b0;
    bus.waiting_global = 1'b1;
    #1;
    checkMain("wait0", 1'b1, 18'h10);
    checkOutput("wait0.fetch_count", bus.fetch_count, 32'd12);
    for (int i = 1; i < 20; i++) begin
      @(negedge clock);
      #1;
      checkMain($sformatf("wait%0d", i), 1'b1, 18'h10);
      checkOutput($sformatf("wait%0d.code_addr", i), 32'(bus.code_addr), 32'h10);
      checkOutput($sformatf("wait%0d.fetch_count", i), bus.fetch_count, 32'd12);
    end
    applyReset(2);
    #1;
    checkMain("wait_rst_c0", 1'b1, 18'h0);
    @(negedge clock);
    #1;
    checkMain("wait_rst_c1", 1'b0, 18'h0);

    // Address wrap at the top of the code space.
    @(negedge clock);
    bus.call_performed = 1'b1;
    bus.ip_to_call     = 18'h3FFFF;
    #1;
    checkMain("wrap_pre", 1'b0, 18'h1);
    @(negedge clock);
    bus.call_performed = 1'b0;
    #1;
    checkMain("wrap_top", 1'b0, 18'h3FFFF);
    checkOutput("wrap_top.code_addr", 32'(bus.code_addr), 32'd0);
    @(negedge clock);
    #1;
    checkMain("wrap_zero", 1'b0, 18'h0);

    // Debug halt on the word at 7, then release.
    @(negedge clock);
    bus.call_performed = 1'b1;
    bus.ip_to_call     = 18'h6;
    #1;
    checkMain("halt_pre", 1'b0, 18'h1);
    @(negedge clock);
    bus.call_performed = 1'b0;
    #1;
    checkMain("halt_ip6", 1'b0, 18'h6);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      bus.debug_halt = 1'b1;
      #1;
      checkMain($sformatf("halt%0d", i), 1'b1, 18'h7);
      checkOutput($sformatf("halt%0d.code_addr", i), 32'(bus.code_addr), 32'h7);
    end
    @(negedge clock);
    bus.debug_halt = 1'b0;
    #1;
    checkMain("halt_rel", 1'b0, 18'h7);
    @(negedge clock);
    #1;
    checkMain("halt_next", 1'b0, 18'h8);

    // 4-bit counter build: counts 0..15 then sticks.
    applyReset(2);
    for (int k = 0; k < 25; k++) begin
      if (k > 0) @(negedge clock);
      #1;
      checkOutput($sformatf("sat%0d.fetch_count", k), 32'(sbus.fetch_count),
                  (k == 0) ? 32'd0 : ((k - 1 > 15) ? 32'd15 : 32'(k - 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
